// File: rtl/mips_alu_exec_unit_if.sv
// Command, result and debug-read bundle between instruction decode and the execute unit.
// The master side drives commands and the debug address; the slave side is the execute unit.
interface mips_alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    read_address1;
    logic [AW-1:0]    read_address2;
    logic [AW-1:0]    write_address;
    logic [3:0]       func;
    logic             write_enable;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             isZero;
    logic             overflow;
    logic [AW-1:0]    dbg_address;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output cmd_valid, read_address1, read_address2, write_address, func, write_enable,
        output dbg_address,
        input  cmd_ready, result, result_valid, isZero, overflow, dbg_data
    );

    modport slave (
        input  cmd_valid, read_address1, read_address2, write_address, func, write_enable,
        input  dbg_address,
        output cmd_ready, result, result_valid, isZero, overflow, dbg_data
    );
endinterface

// File: rtl/mips_alu_exec_unit.sv
// Register file plus ALU execute stage: single-cycle logic/arith/shift ops and an
// iterative shift-add multiply, with a valid/ready command port and a debug read port.
module mips_alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_alu_exec_unit_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] FN_AND = 4'd0;
    localparam logic [3:0] FN_OR  = 4'd1;
    localparam logic [3:0] FN_ADD = 4'd2;
    localparam logic [3:0] FN_XOR = 4'd3;
    localparam logic [3:0] FN_SLL = 4'd4;
    localparam logic [3:0] FN_SRL = 4'd5;
    localparam logic [3:0] FN_SUB = 4'd6;
    localparam logic [3:0] FN_SLT = 4'd7;
    localparam logic [3:0] FN_MUL = 4'd8;
    localparam logic [3:0] FN_NOR = 4'd12;

    logic [WIDTH-1:0] rf_rd [NREGS];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Register 0 is a constant; every other entry is cleared by reset.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_rd[gi] = '0;
            end else begin : g_live
                logic [WIDTH-1:0] reg_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        reg_q <= '0;
                    end else if (wr_en && (wr_addr == AW'(gi))) begin
                        reg_q <= wr_data;
                    end
                end
                assign rf_rd[gi] = reg_q;
            end
        end
    endgenerate

    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    assign rs_val = rf_rd[bus.read_address1];
    assign rt_val = rf_rd[bus.read_address2];

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.func)
            FN_AND: alu_res = rs_val & rt_val;
            FN_OR:  alu_res = rs_val | rt_val;
            FN_XOR: alu_res = rs_val ^ rt_val;
            FN_NOR: alu_res = ~(rs_val | rt_val);
            FN_ADD: begin
                alu_res = rs_val + rt_val;
                alu_ovf = (rs_val[WIDTH-1] == rt_val[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != rs_val[WIDTH-1]);
            end
            FN_SUB: begin
                alu_res = rs_val - rt_val;
                alu_ovf = (rs_val[WIDTH-1] != rt_val[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != rs_val[WIDTH-1]);
            end
            FN_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
            FN_SLL: alu_res = rs_val << rt_val[SW-1:0];
            FN_SRL: alu_res = rs_val >> rt_val[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [SW-1:0]    cnt_q,    cnt_d;
    logic [AW-1:0]    rd_q,     rd_d;
    logic             wen_q,    wen_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
    logic             valid_q,  valid_d;

    logic [WIDTH-1:0] acc_sum;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = bus.write_address;
        wr_data  = alu_res;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.func == FN_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = rs_val;
                        mplier_d = rt_val;
                        acc_d    = '0;
                        cnt_d    = '0;
                        rd_d     = bus.write_address;
                        wen_d    = bus.write_enable;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        valid_d  = 1'b1;
                        wr_en    = bus.write_enable;
                    end
                end
            end
            default: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                // Last iteration commits the accumulate of the final multiplier bit.
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                    ovf_d    = 1'b0;
                    valid_d  = 1'b1;
                    wr_en    = wen_q;
                    wr_addr  = rd_q;
                    wr_data  = acc_sum;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.isZero       = zero_q;
    assign bus.overflow     = ovf_q;
    assign bus.dbg_data     = rf_rd[bus.dbg_address];

endmodule
